// File: rtl/guess_engine_pkg.sv
// Shared types for the guess engine: FSM state encoding and the A-Z letter folding
// used by the missed-letter history.
package guess_engine_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      SCAN   = 3'd2,
      UPDATE = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int NO_LETTER = 0;

   typedef struct packed {
      logic       vld;
      logic [4:0] idx;
   } alpha_t;

   // Upper and lower case map to the same slot; anything else is not a letter.
   function automatic alpha_t to_alpha_idx(input logic [31:0] letter);
      alpha_t a;
      a = '0;
      if (letter >= 32'h41 && letter <= 32'h5A) begin
         a.vld = 1'b1;
         a.idx = 5'(letter - 32'h41);
      end else if (letter >= 32'h61 && letter <= 32'h7A) begin
         a.vld = 1'b1;
         a.idx = 5'(letter - 32'h61);
      end
      return a;
   endfunction

endpackage

// File: rtl/guess_engine_if.sv
// Host/display bus of the guess engine: word load, guess handshake and game status.
interface guess_engine_if #(
   parameter int WORD_LEN = 5,
   parameter int LETTER_W = 8,
   parameter int MAX_MISS = 6
);
   localparam int CNT_W  = $clog2(WORD_LEN + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 1);

   logic                         start;
   logic                         abort;
   logic [WORD_LEN*LETTER_W-1:0] word;
   logic                         guess_valid;
   logic [LETTER_W-1:0]          guess;
   logic                         guess_ready;
   logic                         busy;
   logic [WORD_LEN-1:0]          hit_mask;
   logic [CNT_W-1:0]             found_cnt;
   logic [MISS_W-1:0]            miss_cnt;
   logic                         result_valid;
   logic                         mistake;
   logic                         repeat_guess;
   logic                         win;
   logic                         lose;

   modport master (
      output start, abort, word, guess_valid, guess,
      input  guess_ready, busy, hit_mask, found_cnt, miss_cnt,
             result_valid, mistake, repeat_guess, win, lose
   );

   modport slave (
      input  start, abort, word, guess_valid, guess,
      output guess_ready, busy, hit_mask, found_cnt, miss_cnt,
             result_valid, mistake, repeat_guess, win, lose
   );
endinterface

// File: rtl/guess_engine_letter_history.sv
// 26-entry set of missed letters (case-folded); non-letters are never stored or hit.
module letter_history
   import guess_engine_pkg::*;
#(
   parameter int LETTER_W = 8
) (
   input  logic                clk,
   input  logic                nRst,
   input  logic                i_clear,
   input  logic                i_record,
   input  logic [LETTER_W-1:0] i_query,
   output logic                o_hit
);
   alpha_t      w_alpha;
   logic [25:0] r_set;

   assign w_alpha = to_alpha_idx(32'(i_query));
   assign o_hit   = w_alpha.vld && r_set[w_alpha.idx];

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)
         r_set <= '0;
      else if (i_clear)
         r_set <= '0;
      else if (i_record && w_alpha.vld)
         r_set[w_alpha.idx] <= 1'b1;
   end
endmodule

// File: rtl/guess_engine.sv
// Letter-guessing core: latches a word, scans one position per cycle per guess and
// tracks hits, misses and win/lose. GUESS_HISTORY_EN adds a missed-letter history.
module guess_engine
   import guess_engine_pkg::*;
#(
   parameter int WORD_LEN = 5,
   parameter int LETTER_W = 8,
   parameter int MAX_MISS = 6
) (
   input logic           clk,
   input logic           nRst,
   guess_engine_if.slave bus
);
   localparam int CNT_W  = $clog2(WORD_LEN + 1);
   localparam int MISS_W = $clog2(MAX_MISS + 1);
   localparam int IDX_W  = $clog2(WORD_LEN);

   state_t                             r_state, w_state_nxt;
   logic [WORD_LEN-1:0][LETTER_W-1:0]  r_word;
   logic [LETTER_W-1:0]                r_letter;
   logic [IDX_W-1:0]                   r_idx;
   logic [CNT_W-1:0]                   r_new, r_dup, r_found;
   logic [MISS_W-1:0]                  r_miss;
   logic [WORD_LEN-1:0]                r_mask;
   logic                               r_win, r_lose;

   logic [IDX_W-1:0]  w_pos;
   logic              w_match, w_hs, w_hist_hit, w_miss, w_rep;
   logic              w_ready, w_busy, w_rv;
   logic [CNT_W-1:0]  w_found_nxt;
   logic [MISS_W-1:0] w_miss_nxt;

   // Position 0 is the MSB letter and the MSB mask bit, so both index by w_pos.
   assign w_pos       = IDX_W'(WORD_LEN - 1) - r_idx;
   assign w_match     = (r_word[w_pos] == r_letter);
   assign w_hs        = (r_state == ARMED) && bus.guess_valid && (bus.guess != LETTER_W'(NO_LETTER));
   assign w_found_nxt = r_found + r_new;
   assign w_miss      = (r_state == UPDATE) && (r_new == '0) && (r_dup == '0) && !w_hist_hit;
   assign w_rep       = (r_state == UPDATE) && (r_new == '0) && ((r_dup != '0) || w_hist_hit);
   assign w_miss_nxt  = (w_miss && r_miss != MISS_W'(MAX_MISS)) ? r_miss + 1'b1 : r_miss;

`ifdef GUESS_HISTORY_EN
   letter_history #(.LETTER_W(LETTER_W)) u_hist (
      .clk      (clk),
      .nRst     (nRst),
      .i_clear  (bus.abort || (r_state == IDLE && bus.start)),
      .i_record (w_miss),
      .i_query  (r_letter),
      .o_hit    (w_hist_hit)
   );
`else
   assign w_hist_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_busy      = 1'b0;
      w_rv        = 1'b0;
      case (r_state)
         IDLE:   if (bus.start) w_state_nxt = ARMED;
         ARMED: begin
            w_ready = 1'b1;
            if (w_hs) w_state_nxt = SCAN;
         end
         SCAN: begin
            w_busy = 1'b1;
            if (r_idx == IDX_W'(WORD_LEN - 1)) w_state_nxt = UPDATE;
         end
         UPDATE: begin
            w_busy = 1'b1;
            w_rv   = 1'b1;
            w_state_nxt = (w_found_nxt == CNT_W'(WORD_LEN) || w_miss_nxt == MISS_W'(MAX_MISS))
                          ? DONE : ARMED;
         end
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
      // An aborted in-flight guess must not report a result.
      if (bus.abort) begin
         w_state_nxt = IDLE;
         w_rv        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_word   <= '0;
         r_letter <= '0;
         r_idx    <= '0;
         r_new    <= '0;
         r_dup    <= '0;
         r_mask   <= '0;
         r_found  <= '0;
         r_miss   <= '0;
         r_win    <= 1'b0;
         r_lose   <= 1'b0;
      end else if (bus.abort) begin
         r_mask  <= '0;
         r_found <= '0;
         r_miss  <= '0;
         r_win   <= 1'b0;
         r_lose  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_word  <= bus.word;
               r_mask  <= '0;
               r_found <= '0;
               r_miss  <= '0;
               r_win   <= 1'b0;
               r_lose  <= 1'b0;
            end
            ARMED: if (w_hs) begin
               r_letter <= bus.guess;
               r_idx    <= '0;
               r_new    <= '0;
               r_dup    <= '0;
            end
            SCAN: begin
               r_idx <= r_idx + 1'b1;
               if (w_match) begin
                  if (r_mask[w_pos]) r_dup <= r_dup + 1'b1;
                  else begin
                     r_mask[w_pos] <= 1'b1;
                     r_new         <= r_new + 1'b1;
                  end
               end
            end
            UPDATE: begin
               r_found <= w_found_nxt;
               r_miss  <= w_miss_nxt;
               r_win   <= (w_found_nxt == CNT_W'(WORD_LEN));
               r_lose  <= (w_miss_nxt == MISS_W'(MAX_MISS));
            end
            default: ;
         endcase
      end
   end

   assign bus.guess_ready  = w_ready;
   assign bus.busy         = w_busy;
   assign bus.result_valid = w_rv;
   assign bus.mistake      = w_rv && w_miss;
   assign bus.repeat_guess = w_rv && w_rep;
   assign bus.hit_mask     = r_mask;
   assign bus.found_cnt    = r_found;
   assign bus.miss_cnt     = r_miss;
   assign bus.win          = r_win;
   assign bus.lose         = r_lose;
endmodule

// File: tb/tb_guess_engine.sv
// Scoreboard bench for guess_engine: a driver pushes model results, a monitor checks them.
module tb_guess_engine;
   localparam int WL = 5;
   localparam int LW = 8;
   localparam int MM = 6;
`ifdef GUESS_HISTORY_EN
   localparam bit HIST = 1'b1;
`else
   localparam bit HIST = 1'b0;
`endif

   typedef struct {
      logic          mistake;
      logic          rep;
      logic [WL-1:0] mask;
      int            found;
      int            miss;
      logic          win;
      logic          lose;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic nRst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   // Reference game state: letters by position, revealed flags, misses, missed-letter set.
   logic [LW-1:0] m_word [WL];
   bit            m_rev  [WL];
   bit            m_hist [26];
   int            m_miss;
   bit            m_over;

   guess_engine_if #(.WORD_LEN(WL), .LETTER_W(LW), .MAX_MISS(MM)) bus ();
   guess_engine #(.WORD_LEN(WL), .LETTER_W(LW), .MAX_MISS(MM)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int fold(input logic [7:0] g);
      if (g >= 8'h41 && g <= 8'h5A) return int'(g) - 65;
      if (g >= 8'h61 && g <= 8'h7A) return int'(g) - 97;
      return -1;
   endfunction

   function automatic exp_t model(input logic [LW-1:0] g);
      exp_t e;
      int   nnew = 0;
      int   ndup = 0;
      int   f    = fold(g);
      for (int i = 0; i < WL; i++)
         if (m_word[i] == g) begin
            if (m_rev[i]) ndup++;
            else begin m_rev[i] = 1'b1; nnew++; end
         end
      e.mistake = 1'b0;
      e.rep     = 1'b0;
      if (nnew == 0) begin
         if (ndup > 0) e.rep = 1'b1;
         else if (HIST && f >= 0 && m_hist[f]) e.rep = 1'b1;
         else begin
            e.mistake = 1'b1;
            if (m_miss < MM) m_miss++;
            if (HIST && f >= 0) m_hist[f] = 1'b1;
         end
      end
      e.found = 0;
      for (int i = 0; i < WL; i++) begin
         e.mask[WL-1-i] = m_rev[i];
         if (m_rev[i]) e.found++;
      end
      e.miss = m_miss;
      e.win  = (e.found == WL);
      e.lose = (m_miss == MM);
      e.cyc  = 0;
      m_over = e.win || e.lose;
      return e;
   endfunction

   function automatic logic [LW-1:0] rand_letter();
      int r = $urandom_range(0, 99);
      if (r < 70) return 8'h41 + 8'($urandom_range(0, 9));
      if (r < 85) return 8'h61 + 8'($urandom_range(0, 9));
      return 8'h30 + 8'($urandom_range(0, 9));
   endfunction

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
      chk("scoreboard_empty", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic new_game(input logic [8*WL-1:0] w);
      drain();
      @(negedge clk);
      bus.abort = 1'b1; bus.start = 1'b1; bus.word = w;
      @(negedge clk);
      chk("abort_beats_start", 32'(bus.guess_ready), 0);
      bus.abort = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.word  = {WL{8'h5A}};
      @(negedge clk);
      chk("armed_ready", 32'(bus.guess_ready), 1);
      chk("armed_found", 32'(bus.found_cnt), 0);
      chk("armed_miss", 32'(bus.miss_cnt), 0);
      chk("armed_mask", 32'(bus.hit_mask), 0);
      chk("armed_winlose", 32'({bus.win, bus.lose}), 0);
      for (int i = 0; i < WL; i++) begin
         m_word[i] = w[(WL-1-i)*8 +: 8];
         m_rev[i]  = 1'b0;
      end
      for (int i = 0; i < 26; i++) m_hist[i] = 1'b0;
      m_miss = 0;
      m_over = 1'b0;
   endtask

   task automatic do_guess(input logic [LW-1:0] g);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      while (!bus.guess_ready && t < 100) begin @(negedge clk); t++; end
      chk("guess_ready_wait", 32'(bus.guess_ready), 1);
      if (bus.guess_ready) begin
         e = model(g);
         bus.guess_valid = 1'b1; bus.guess = g;
         @(posedge clk); #1;
         e.cyc = cyc + WL;
         sb.push_back(e);
         bus.guess_valid = 1'b0; bus.guess = '0;
      end
   endtask

   task automatic drop_zero();
      int t = 0;
      @(negedge clk);
      while (!bus.guess_ready && t < 100) begin @(negedge clk); t++; end
      bus.guess_valid = 1'b1; bus.guess = '0;
      @(negedge clk);
      chk("zero_dropped_ready", 32'(bus.guess_ready), 1);
      chk("zero_dropped_busy", 32'(bus.busy), 0);
      bus.guess_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_result: result_valid at cycle %0d, expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc, e.cyc);
               chk("mistake", 32'(bus.mistake), 32'(e.mistake));
               chk("repeat_guess", 32'(bus.repeat_guess), 32'(e.rep));
               chk("hit_mask", 32'(bus.hit_mask), 32'(e.mask));
               @(negedge clk);
               chk("found_cnt", 32'(bus.found_cnt), e.found);
               chk("miss_cnt", 32'(bus.miss_cnt), e.miss);
               chk("win", 32'(bus.win), 32'(e.win));
               chk("lose", 32'(bus.lose), 32'(e.lose));
            end
         end
      end
   end

   initial begin : stim
      logic [8*WL-1:0] w;
      bus.start = 1'b0; bus.abort = 1'b0; bus.word = '0;
      bus.guess_valid = 1'b0; bus.guess = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({bus.guess_ready, bus.busy, bus.result_valid, bus.win, bus.lose}), 0);
      nRst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.guess_ready), 0);
      chk("idle_counts", 32'({bus.hit_mask, bus.found_cnt, bus.miss_cnt}), 0);

      // HELLO: hit, repeat, then six misses to a loss
      new_game(40'h48454C4C4F);
      do_guess(8'h4C);
      do_guess(8'h4C);
      drop_zero();
      do_guess(8'h5A); do_guess(8'h51); do_guess(8'h58);
      do_guess(8'h57); do_guess(8'h56); do_guess(8'h4B);
      drain();
      chk("lost_flag", 32'(bus.lose), 1);
      chk("lost_win_clear", 32'(bus.win), 0);
      @(negedge clk);
      bus.guess_valid = 1'b1; bus.guess = 8'h48; bus.start = 1'b1;
      repeat (WL + 3) begin
         @(negedge clk);
         chk("done_no_ready", 32'(bus.guess_ready), 0);
         chk("done_lose_held", 32'(bus.lose), 1);
      end
      bus.guess_valid = 1'b0; bus.guess = '0; bus.start = 1'b0;

      // HELLO: full reveal to a win
      new_game(40'h48454C4C4F);
      do_guess(8'h48); do_guess(8'h45); do_guess(8'h4C); do_guess(8'h4F);
      drain();
      chk("won_flag", 32'(bus.win), 1);
      chk("won_mask", 32'(bus.hit_mask), 32'h1F);
      chk("won_no_ready", 32'(bus.guess_ready), 0);

      // Abort while a guess is scanning
      new_game(40'h48454C4C4F);
      do_guess(8'h4C);
      drain();
      @(negedge clk);
      bus.guess_valid = 1'b1; bus.guess = 8'h45;
      @(negedge clk);
      bus.guess_valid = 1'b0; bus.guess = '0;
      chk("scan_busy", 32'(bus.busy), 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_ready", 32'(bus.guess_ready), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_state", 32'({bus.hit_mask, bus.found_cnt, bus.miss_cnt, bus.win, bus.lose}), 0);
      chk("abort_no_result", 32'(bus.result_valid), 0);
      repeat (WL + 3) @(negedge clk);

      // Same miss twice: history turns the second into a repeat
      new_game(40'h48454C4C4F);
      do_guess(8'h5A);
      do_guess(8'h5A);
      drain();
      chk("zz_miss_cnt", 32'(bus.miss_cnt), HIST ? 1 : 2);

      // Random games
      for (int gm = 0; gm < 25; gm++) begin
         for (int i = 0; i < WL; i++) w[i*8 +: 8] = 8'h41 + 8'($urandom_range(0, 7));
         new_game(w);
         for (int k = 0; k < 40 && !m_over; k++) begin
            if ($urandom_range(0, 99) < 5) drop_zero();
            else do_guess(rand_letter());
         end
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
